// File: rtl/dmem_pkg.sv
// Shared definitions for the line-granular data memory: line geometry,
// controller state encoding and the address-to-line-index helper.
package dmem_pkg;

  localparam int LINE_W_DEF       = 256;
  localparam int LINE_OFFSET_BITS = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_ACK  = ST_ACK
  } state_e;

  // Drops the byte offset and keeps depth_log2 index bits, so any upper
  // address bits alias onto the array (addresses wrap modulo its size).
  function automatic logic [31:0] line_index(input logic [31:0] addr,
                                             input int          depth_log2);
    logic [31:0] mask;
    mask = (32'd1 << depth_log2) - 32'd1;
    return (addr >> LINE_OFFSET_BITS) & mask;
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Single-port synchronous line storage with a registered read port.
// Read-before-write: on a write edge rdata returns the previous contents.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int LINE_W     = LINE_W_DEF,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [LINE_W-1:0]     wdata,
  input  logic                  we,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

  // Storage update and registered read of the addressed line.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_line_ctrl.sv
// Line memory controller for the data cache's miss / write-back traffic.
// Accepts one read-line or write-line request at a time, counts down a
// fixed access latency, performs the access and pulses ack_o for one cycle.
module dmem_line_ctrl
  import dmem_pkg::*;
#(
  parameter int LINE_W     = LINE_W_DEF,
  parameter int DEPTH_LOG2 = 9,
  parameter int LATENCY    = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  state_e                  state;
  logic [7:0]              cnt_p0;
  logic [DEPTH_LOG2-1:0]   idx_p0;
  logic                    wr_p0;
  logic [LINE_W-1:0]       wdata_p0;

  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [DEPTH_LOG2-1:0]   arr_idx;
  logic                    access_now;
  logic                    arr_we;
  logic [LINE_W-1:0]       arr_rdata;

  assign req_idx = DEPTH_LOG2'(line_index(addr_i, DEPTH_LOG2));

  // While idle the array is pointed at the incoming address so its
  // registered read is already valid for the latched line by the time the
  // countdown expires, even at the shortest latency.
  assign arr_idx    = (state == S_IDLE) ? req_idx : idx_p0;
  assign access_now = (state == S_WAIT) && (cnt_p0 == 8'd0);
  assign arr_we     = access_now && wr_p0;

  dmem_line_array #(
    .LINE_W     (LINE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk_i),
    .index (arr_idx),
    .wdata (wdata_p0),
    .we    (arr_we),
    .rdata (arr_rdata)
  );

  // Request FSM: latch on accept, count down, access + ack, then one ack
  // cycle before returning to idle. Reset drops any in-flight request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      cnt_p0   <= 8'd0;
      idx_p0   <= '0;
      wr_p0    <= 1'b0;
      wdata_p0 <= '0;
      ack_o    <= 1'b0;
      data_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ack_o <= 1'b0;
          if (enable_i) begin
            idx_p0   <= req_idx;
            wr_p0    <= write_i;
            wdata_p0 <= data_i;
            cnt_p0   <= 8'(LATENCY - 1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_p0 == 8'd0) begin
            if (!wr_p0) begin
              data_o <= arr_rdata;
            end
            ack_o <= 1'b1;
            state <= S_ACK;
          end else begin
            cnt_p0 <= cnt_p0 - 8'd1;
          end
        end
        S_ACK: begin
          ack_o <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ack_o <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Bench for dmem_line_ctrl: a LATENCY=10 instance and a LATENCY=1 instance,
// each compared against a line-array reference model held in the bench.
module tb_dmem_line_ctrl;

  localparam int LW = 256;
  localparam int DL = 9;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;

  logic [31:0]   a0, a1;
  logic [LW-1:0] d0, d1;
  logic          en0, en1, wr0, wr1;
  logic          ack0, ack1;
  logic [LW-1:0] q0, q1;

  dmem_line_ctrl #(.LINE_W(LW), .DEPTH_LOG2(DL), .LATENCY(10)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .addr_i(a0), .data_i(d0),
    .enable_i(en0), .write_i(wr0), .ack_o(ack0), .data_o(q0)
  );

  dmem_line_ctrl #(.LINE_W(LW), .DEPTH_LOG2(DL), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .addr_i(a1), .data_i(d1),
    .enable_i(en1), .write_i(wr1), .ack_o(ack1), .data_o(q1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: line contents per instance, last line read per instance.
  logic [LW-1:0] mem_m [2][512];
  logic [LW-1:0] last_rd [2];
  int            lat [2] = '{10, 1};
  int            last_ack [2];

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic get_ack(input int s);
    return (s == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [LW-1:0] get_data(input int s);
    return (s == 0) ? q0 : q1;
  endfunction

  task automatic drive(input int s, input logic e, input logic w,
                       input logic [31:0] a, input logic [LW-1:0] d);
    if (s == 0) begin
      en0 = e; wr0 = w; a0 = a; d0 = d;
    end else begin
      en1 = e; wr1 = w; a1 = a; d1 = d;
    end
  endtask

  task automatic set_en(input int s, input logic e);
    if (s == 0) en0 = e;
    else        en1 = e;
  endtask

  // One request: present it, scramble inputs while busy, wait (bounded)
  // for ack, compare latency and data, then confirm ack lasts one cycle.
  task automatic req(input int s, input bit w, input logic [31:0] a,
                     input logic [LW-1:0] d, input bit hold);
    int idx;
    int n;
    idx = int'((a >> 5) & 32'd511);
    drive(s, 1'b1, w, a, d);
    @(posedge clk); #1;
    drive(s, 1'b1, 1'($urandom_range(0, 1)), $urandom, rnd_line());
    n = 0;
    while (!get_ack(s) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(w ? "wr_latency" : "rd_latency", LW'(n), LW'(lat[s]));
    last_ack[s] = cyc;
    if (w) mem_m[s][idx] = d;
    else   last_rd[s] = mem_m[s][idx];
    chk(w ? "wr_data_o_held" : "rd_data", get_data(s), last_rd[s]);
    if (!hold) set_en(s, 1'b0);
    @(posedge clk); #1;
    chk("ack_one_cycle", LW'(get_ack(s)), '0);
  endtask

  initial begin : main
    logic [LW-1:0] pa, pb, pc, old;
    logic [31:0]   ra;
    int            t, n_ack, s;

    drive(0, 1'b0, 1'b0, 32'd0, '0);
    drive(1, 1'b0, 1'b0, 32'd0, '0);
    #2 rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0",  LW'(ack0), '0);
    chk("rst_data0", q0, '0);
    chk("rst_ack1",  LW'(ack1), '0);
    chk("rst_data1", q1, '0);
    rst_i = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Idle with enable low: no ack at all.
    n_ack = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (ack0) n_ack++;
    end
    chk("idle_no_ack", LW'(n_ack), '0);
    chk("idle_data0", q0, '0);

    // Preload the lines the random phase uses.
    for (int i = 0; i < 16; i++) begin
      req(0, 1'b1, 32'(i) << 5, rnd_line(), 1'b0);
      req(1, 1'b1, 32'(i) << 5, rnd_line(), 1'b0);
    end
    req(0, 1'b1, 32'h0000_0200, rnd_line(), 1'b0);

    // Write then read, offset bits ignored.
    req(0, 1'b1, 32'h0000_0400, {8{32'hDEADBEEF}}, 1'b1);
    req(0, 1'b0, 32'h0000_041C, '0, 1'b0);
    chk("rw_deadbeef", q0, {8{32'hDEADBEEF}});

    // Address wrap onto index 1.
    pa = rnd_line();
    req(0, 1'b1, 32'h0000_4020, pa, 1'b0);
    req(0, 1'b0, 32'h0000_0020, '0, 1'b0);
    chk("wrap_read", q0, pa);

    // Back-to-back write-back then read miss, enable held through ack.
    pc = rnd_line();
    req(0, 1'b1, 32'h0000_2000, pc, 1'b0);
    pb = rnd_line();
    req(0, 1'b1, 32'h0000_1000, pb, 1'b1);
    t = last_ack[0];
    req(0, 1'b0, 32'h0000_2000, '0, 1'b0);
    chk("b2b_spacing", LW'(last_ack[0] - t), LW'(12));
    chk("b2b_read_c", q0, pc);
    req(0, 1'b0, 32'h0000_1000, '0, 1'b0);
    chk("b2b_line_b", q0, pb);

    // Reset in the middle of a write: no ack, line keeps its old value.
    old = mem_m[0][16];
    drive(0, 1'b1, 1'b1, 32'h0000_0200, rnd_line());
    @(posedge clk); #1;
    n_ack = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack0) n_ack++;
    end
    rst_i = 1'b0;
    #1;
    chk("midrst_no_ack", LW'(n_ack + int'(ack0)), '0);
    chk("midrst_data0", q0, '0);
    set_en(0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    req(0, 1'b0, 32'h0000_0200, '0, 1'b0);
    chk("midrst_line_kept", q0, old);

    // Single-cycle latency instance.
    req(1, 1'b0, 32'h0000_0040, '0, 1'b1);
    t = last_ack[1];
    req(1, 1'b0, 32'h0000_0040, '0, 1'b0);
    chk("lat1_spacing", LW'(last_ack[1] - t), LW'(3));
    chk("lat1_data", q1, mem_m[1][2]);

    // Randomised traffic on both instances, random upper/offset bits.
    repeat (60) begin
      s = int'($urandom_range(0, 1));
      ra = $urandom;
      ra[13:5] = 9'($urandom_range(0, 15));
      req(s, 1'($urandom_range(0, 1)), ra, rnd_line(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
